// File: rtl/axil_pkg.sv
// Shared types and constants for the AXI4-lite request master and related blocks.
package axil_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = 4;

   localparam logic [2:0] PROT_DATA = 3'b000;
   localparam logic [2:0] PROT_INSN = 3'b100;

   typedef enum logic [2:0] {
      IDLE,
      WR,
      WR_B,
      RD_A,
      RD_R,
      RESP
   } state_e;

endpackage

// File: rtl/axil_req_master.sv
// Converts a valid/ready request/response stream into single-outstanding AXI4-lite
// transactions; AW and W handshakes are tracked independently.
module axil_req_master
   import axil_pkg::*;
#(
   parameter int unsigned TIMEOUT = 0,
   parameter int unsigned CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic              req_insn,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [STRB_W-1:0] req_wstrb,

   output logic              resp_valid,
   input  logic              resp_ready,
   output logic              resp_write,
   output logic [DATA_W-1:0] resp_rdata,

   output logic              mem_axi_awvalid,
   input  logic              mem_axi_awready,
   output logic [ADDR_W-1:0] mem_axi_awaddr,
   output logic [2:0]        mem_axi_awprot,

   output logic              mem_axi_wvalid,
   input  logic              mem_axi_wready,
   output logic [DATA_W-1:0] mem_axi_wdata,
   output logic [STRB_W-1:0] mem_axi_wstrb,

   input  logic              mem_axi_bvalid,
   output logic              mem_axi_bready,

   output logic              mem_axi_arvalid,
   input  logic              mem_axi_arready,
   output logic [ADDR_W-1:0] mem_axi_araddr,
   output logic [2:0]        mem_axi_arprot,

   input  logic              mem_axi_rvalid,
   output logic              mem_axi_rready,
   input  logic [DATA_W-1:0] mem_axi_rdata,

   output logic              timeout
);

   state_e              state_q;
   logic                awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
   logic                aw_done_q, w_done_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [STRB_W-1:0]   wstrb_q;
   logic [2:0]          arprot_q;
   logic                resp_valid_q, resp_write_q;
   logic [DATA_W-1:0]   resp_rdata_q;
   logic                timeout_q;
   logic [CNT_W-1:0]    cnt_q;

   logic                aw_hs, w_hs, bus_wait;

   assign aw_hs    = awvalid_q & mem_axi_awready;
   assign w_hs     = wvalid_q & mem_axi_wready;
   assign bus_wait = (state_q == WR) || (state_q == WR_B) ||
                     (state_q == RD_A) || (state_q == RD_R);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         awvalid_q    <= 1'b0;
         wvalid_q     <= 1'b0;
         bready_q     <= 1'b0;
         arvalid_q    <= 1'b0;
         rready_q     <= 1'b0;
         aw_done_q    <= 1'b0;
         w_done_q     <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         wstrb_q      <= '0;
         arprot_q     <= PROT_DATA;
         resp_valid_q <= 1'b0;
         resp_write_q <= 1'b0;
         resp_rdata_q <= '0;
         timeout_q    <= 1'b0;
         cnt_q        <= '0;
      end else begin
         // Counter saturates; every state transition below reloads it with zero.
         if (bus_wait) begin
            if (cnt_q != '1)
               cnt_q <= cnt_q + CNT_W'(1);
            if (TIMEOUT != 0 && cnt_q == CNT_W'(TIMEOUT - 1))
               timeout_q <= 1'b1;
         end

         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  cnt_q  <= '0;
                  addr_q <= req_addr;
                  if (req_write) begin
                     wdata_q   <= req_wdata;
                     wstrb_q   <= req_wstrb;
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                     state_q   <= WR;
                  end else begin
                     arprot_q  <= req_insn ? PROT_INSN : PROT_DATA;
                     arvalid_q <= 1'b1;
                     state_q   <= RD_A;
                  end
               end
            end

            WR: begin
               if (aw_hs) begin
                  awvalid_q <= 1'b0;
                  aw_done_q <= 1'b1;
               end
               if (w_hs) begin
                  wvalid_q <= 1'b0;
                  w_done_q <= 1'b1;
               end
               if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
                  aw_done_q <= 1'b0;
                  w_done_q  <= 1'b0;
                  bready_q  <= 1'b1;
                  cnt_q     <= '0;
                  state_q   <= WR_B;
               end
            end

            WR_B: begin
               if (mem_axi_bvalid & bready_q) begin
                  bready_q     <= 1'b0;
                  resp_valid_q <= 1'b1;
                  resp_write_q <= 1'b1;
                  resp_rdata_q <= '0;
                  cnt_q        <= '0;
                  state_q      <= RESP;
               end
            end

            RD_A: begin
               if (arvalid_q & mem_axi_arready) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  cnt_q     <= '0;
                  state_q   <= RD_R;
               end
            end

            RD_R: begin
               if (mem_axi_rvalid & rready_q) begin
                  rready_q     <= 1'b0;
                  resp_valid_q <= 1'b1;
                  resp_write_q <= 1'b0;
                  resp_rdata_q <= mem_axi_rdata;
                  cnt_q        <= '0;
                  state_q      <= RESP;
               end
            end

            RESP: begin
               if (resp_ready) begin
                  resp_valid_q <= 1'b0;
                  cnt_q        <= '0;
                  state_q      <= IDLE;
               end
            end

            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready       = (state_q == IDLE);

   assign mem_axi_awvalid = awvalid_q;
   assign mem_axi_awaddr  = addr_q;
   assign mem_axi_awprot  = PROT_DATA;
   assign mem_axi_wvalid  = wvalid_q;
   assign mem_axi_wdata   = wdata_q;
   assign mem_axi_wstrb   = wstrb_q;
   assign mem_axi_bready  = bready_q;
   assign mem_axi_arvalid = arvalid_q;
   assign mem_axi_araddr  = addr_q;
   assign mem_axi_arprot  = arprot_q;
   assign mem_axi_rready  = rready_q;

   assign resp_valid      = resp_valid_q;
   assign resp_write      = resp_write_q;
   assign resp_rdata      = resp_rdata_q;
   assign timeout         = timeout_q;

endmodule

// File: tb/tb_axil_req_master.sv
// Bench for axil_req_master: delay-configurable AXI4-lite slave, response scoreboard
// and a per-cycle AXI handshake rule checker.
module tb_axil_req_master;

   localparam int unsigned TO = 8;

   logic        clk, rst;
   logic        req_valid, req_ready, req_write, req_insn;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_wstrb;
   logic        resp_valid, resp_ready, resp_write;
   logic [31:0] resp_rdata;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic [2:0]  awprot, arprot;
   logic [3:0]  wstrb;
   logic        timeout;

   axil_req_master #(.TIMEOUT(TO), .CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_insn(req_insn), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_write(resp_write),
      .resp_rdata(resp_rdata),
      .mem_axi_awvalid(awvalid), .mem_axi_awready(awready), .mem_axi_awaddr(awaddr),
      .mem_axi_awprot(awprot),
      .mem_axi_wvalid(wvalid), .mem_axi_wready(wready), .mem_axi_wdata(wdata),
      .mem_axi_wstrb(wstrb),
      .mem_axi_bvalid(bvalid), .mem_axi_bready(bready),
      .mem_axi_arvalid(arvalid), .mem_axi_arready(arready), .mem_axi_araddr(araddr),
      .mem_axi_arprot(arprot),
      .mem_axi_rvalid(rvalid), .mem_axi_rready(rready), .mem_axi_rdata(rdata),
      .timeout(timeout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int unsigned b = 0; b < 4; b++)
         if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   logic [31:0] xs_q = 32'h1234_5678;
   function automatic logic [31:0] xs();
      logic [31:0] x;
      x = xs_q;
      x = x ^ (x << 13);
      x = x ^ (x >> 17);
      x = x ^ (x << 5);
      xs_q = x;
      return x;
   endfunction

   // ---------------- scoreboard ----------------
   typedef struct {
      bit          wr;
      logic [31:0] rdata;
      logic [31:0] addr;
      logic [2:0]  prot;
      bit          chk_lat;
      int unsigned acc;
   } exp_t;
   exp_t exp_q[$];

   int unsigned resp_stall = 0;
   int unsigned last_hs = 0;

   // ---------------- slave model ----------------
   logic [31:0] smem [256];
   logic [31:0] rmem [256];
   int unsigned aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
   int unsigned aw_wait, w_wait, b_wait, ar_wait, r_wait;
   bit          aw_got, w_got, ar_got, b_on, r_on, b_hs, r_hs, ar_block;
   logic [31:0] s_awaddr, s_wdata, s_araddr;
   logic [3:0]  s_wstrb;
   logic [31:0] last_awaddr, last_araddr;
   logic [2:0]  last_awprot, last_arprot;

   initial begin
      awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; rdata = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; rdata = '0;
            aw_got = 0; w_got = 0; ar_got = 0; b_on = 0; r_on = 0; b_hs = 0; r_hs = 0;
            aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
         end else begin
            if (b_hs) begin bvalid = 0; b_hs = 0; b_on = 0; aw_got = 0; w_got = 0; end
            if (r_hs) begin rvalid = 0; r_hs = 0; r_on = 0; ar_got = 0; end
            if (aw_got && w_got && !b_on) begin
               if (b_wait >= b_dly) begin
                  smem[s_awaddr[9:2]] = merge(smem[s_awaddr[9:2]], s_wdata, s_wstrb);
                  bvalid = 1; b_on = 1; b_wait = 0;
               end else b_wait++;
            end
            if (bvalid && bready) b_hs = 1;
            if (ar_got && !r_on) begin
               if (r_wait >= r_dly) begin
                  rdata = smem[s_araddr[9:2]]; rvalid = 1; r_on = 1; r_wait = 0;
               end else r_wait++;
            end
            if (rvalid && rready) r_hs = 1;
            awready = 0;
            if (awvalid && !aw_got) begin
               if (aw_wait >= aw_dly) begin
                  awready = 1; aw_got = 1; aw_wait = 0;
                  s_awaddr = awaddr; last_awaddr = awaddr; last_awprot = awprot;
               end else aw_wait++;
            end
            wready = 0;
            if (wvalid && !w_got) begin
               if (w_wait >= w_dly) begin
                  wready = 1; w_got = 1; w_wait = 0; s_wdata = wdata; s_wstrb = wstrb;
               end else w_wait++;
            end
            arready = 0;
            if (arvalid && !ar_got && !ar_block) begin
               if (ar_wait >= ar_dly) begin
                  arready = 1; ar_got = 1; ar_wait = 0;
                  s_araddr = araddr; last_araddr = araddr; last_arprot = arprot;
               end else ar_wait++;
            end
         end
      end
   end

   // ---------------- response monitor ----------------
   initial begin
      bit          in_resp;
      int unsigned first_cyc, stall_left;
      logic        hold_w;
      logic [31:0] hold_d;
      exp_t        e;
      in_resp = 0; resp_ready = 0;
      forever begin
         @(negedge clk);
         if (rst || !resp_valid) begin
            resp_ready = 0; in_resp = 0;
         end else begin
            if (!in_resp) begin
               in_resp = 1; first_cyc = cyc; hold_w = resp_write; hold_d = resp_rdata;
               stall_left = resp_stall;
            end else begin
               chk("resp_hold_write", resp_write, hold_w);
               chk("resp_hold_rdata", resp_rdata, hold_d);
            end
            if (stall_left > 0) begin
               resp_ready = 0; stall_left--;
            end else begin
               resp_ready = 1;
               if (exp_q.size() == 0) begin
                  chk("resp_unexpected", resp_valid, 0);
               end else begin
                  e = exp_q.pop_front();
                  chk("resp_write", resp_write, e.wr);
                  chk("resp_rdata", resp_rdata, e.rdata);
                  if (e.chk_lat) chk("resp_latency", first_cyc - e.acc, 3);
                  if (e.wr) begin
                     chk("awaddr", last_awaddr, e.addr);
                     chk("awprot", last_awprot, e.prot);
                  end else begin
                     chk("araddr", last_araddr, e.addr);
                     chk("arprot", last_arprot, e.prot);
                  end
               end
               last_hs = cyc; in_resp = 0;
            end
         end
      end
   end

   // ---------------- AXI rule checker ----------------
   initial begin
      logic p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_bv, p_br, p_rv, p_rr;
      logic [31:0] p_awaddr, p_wdata, p_araddr;
      logic [2:0]  p_awprot, p_arprot;
      logic [3:0]  p_wstrb;
      bit aw_seen, w_seen, ar_seen;
      forever begin
         @(negedge clk);
         #1;
         if (rst) begin
            {p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_bv, p_br, p_rv, p_rr} = '0;
            aw_seen = 0; w_seen = 0; ar_seen = 0;
         end else begin
            if (p_awv && p_awr) begin
               aw_seen = 1; chk("aw_drop_after_hs", awvalid, 0);
            end else if (p_awv) begin
               chk("aw_valid_held", awvalid, 1);
               chk("aw_addr_stable", awaddr, p_awaddr);
               chk("aw_prot_stable", awprot, p_awprot);
            end
            if (p_wv && p_wr) begin
               w_seen = 1; chk("w_drop_after_hs", wvalid, 0);
            end else if (p_wv) begin
               chk("w_valid_held", wvalid, 1);
               chk("w_data_stable", wdata, p_wdata);
               chk("w_strb_stable", wstrb, p_wstrb);
            end
            if (p_arv && p_arr) begin
               ar_seen = 1; chk("ar_drop_after_hs", arvalid, 0);
            end else if (p_arv) begin
               chk("ar_valid_held", arvalid, 1);
               chk("ar_addr_stable", araddr, p_araddr);
               chk("ar_prot_stable", arprot, p_arprot);
            end
            if (p_bv && p_br) begin aw_seen = 0; w_seen = 0; end
            if (p_rv && p_rr) ar_seen = 0;
            if (bready) chk("bready_after_aw_and_w", aw_seen && w_seen, 1);
            if (rready) chk("rready_after_ar", ar_seen, 1);
            if (req_ready)
               chk("req_ready_while_busy", awvalid | wvalid | arvalid | bready | rready | resp_valid, 0);
            p_awv = awvalid; p_awr = awready; p_awaddr = awaddr; p_awprot = awprot;
            p_wv = wvalid; p_wr = wready; p_wdata = wdata; p_wstrb = wstrb;
            p_arv = arvalid; p_arr = arready; p_araddr = araddr; p_arprot = arprot;
            p_bv = bvalid; p_br = bready; p_rv = rvalid; p_rr = rready;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic issue(input bit wr, input bit insn, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [31:0] exp_rd, input logic [2:0] exp_prot,
                        input bit chk_lat, input bit push, output int unsigned acc);
      exp_t e;
      int unsigned n;
      req_valid = 1; req_write = wr; req_insn = insn; req_addr = a; req_wdata = d; req_wstrb = s;
      n = 0;
      while (!req_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      acc = 0;
      if (!req_ready) begin
         miscompares++;
         $display("FAIL req_accept: got no req_ready within %0d cycles, want acceptance", n);
      end else begin
         acc = cyc;
         if (push) begin
            e.wr = wr; e.rdata = exp_rd; e.addr = a; e.prot = exp_prot;
            e.chk_lat = chk_lat; e.acc = acc;
            exp_q.push_back(e);
         end
         @(negedge clk);
      end
      req_valid = 0;
   endtask

   task automatic drain();
      int unsigned n;
      n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d responses outstanding, want 0", exp_q.size());
         exp_q.delete();
      end
      @(negedge clk);
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_req_ready"}, req_ready, 1);
      chk({tag, "_awvalid"}, awvalid, 0);
      chk({tag, "_wvalid"}, wvalid, 0);
      chk({tag, "_bready"}, bready, 0);
      chk({tag, "_arvalid"}, arvalid, 0);
      chk({tag, "_rready"}, rready, 0);
      chk({tag, "_resp_valid"}, resp_valid, 0);
      chk({tag, "_resp_write"}, resp_write, 0);
      chk({tag, "_resp_rdata"}, resp_rdata, 0);
      chk({tag, "_timeout"}, timeout, 0);
   endtask

   initial begin
      int unsigned acc, acc2;
      logic [31:0] r, d, a;
      logic [3:0]  idx;
      bit          zero;
      rst = 1; req_valid = 0; req_write = 0; req_insn = 0;
      req_addr = '0; req_wdata = '0; req_wstrb = '0; ar_block = 0;
      for (int i = 0; i < 256; i++) begin smem[i] = '0; rmem[i] = '0; end
      @(negedge clk);
      @(negedge clk);
      reset_checks("por");
      rst = 0;
      @(negedge clk);

      // zero-wait write then readback
      issue(1, 0, 32'h100, 32'hDEADBEEF, 4'hF, 32'h0, 3'b000, 1, 1, acc);
      issue(0, 0, 32'h100, 32'h0, 4'h0, 32'hDEADBEEF, 3'b000, 1, 1, acc);
      drain();

      // W accepted two cycles ahead of AW, partial strobe merge
      aw_dly = 2;
      issue(1, 0, 32'h104, 32'hFFFFFFFF, 4'hF, 32'h0, 3'b000, 0, 1, acc);
      drain();
      issue(1, 0, 32'h104, 32'h12345678, 4'b0011, 32'h0, 3'b000, 0, 1, acc);
      drain();
      aw_dly = 0;
      issue(0, 0, 32'h104, 32'h0, 4'h0, 32'hFFFF5678, 3'b000, 1, 1, acc);
      drain();

      // instruction fetches
      ar_dly = 2;
      issue(0, 1, 32'h0, 32'h0, 4'h0, 32'h0, 3'b100, 0, 1, acc);
      drain();
      ar_dly = 0;
      issue(0, 1, 32'h100, 32'h0, 4'h0, 32'hDEADBEEF, 3'b100, 1, 1, acc);
      drain();

      // response back-pressure with a second request already waiting
      resp_stall = 5;
      issue(1, 0, 32'h108, 32'hA5A5A5A5, 4'hF, 32'h0, 3'b000, 1, 1, acc);
      issue(0, 0, 32'h108, 32'h0, 4'h0, 32'hA5A5A5A5, 3'b000, 1, 1, acc2);
      resp_stall = 0;
      chk("accept_after_resp_hs", acc2, last_hs + 1);
      drain();

      // randomised slave delays
      for (int unsigned n = 0; n < 1000; n++) begin
         r = xs();
         d = xs();
         idx = r[5:2];
         a = 32'h200 + {26'd0, idx, 2'b00};
         aw_dly = r[11:10]; w_dly = r[13:12]; b_dly = r[15:14];
         ar_dly = r[17:16]; r_dly = r[19:18]; resp_stall = r[21:20];
         if (r[0]) begin
            zero = (r[15:10] == 6'd0);
            rmem[128 + idx] = merge(rmem[128 + idx], d, r[9:6]);
            issue(1, 0, a, d, r[9:6], 32'h0, 3'b000, zero, 1, acc);
         end else begin
            zero = (r[19:16] == 4'd0);
            issue(0, r[1], a, 32'h0, 4'h0, rmem[128 + idx], r[1] ? 3'b100 : 3'b000, zero, 1, acc);
         end
         drain();
      end
      aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0; resp_stall = 0;
      chk("timeout_after_random", timeout, 0);

      // stuck AR channel trips the timeout; reset recovers
      ar_block = 1;
      issue(0, 0, 32'h40, 32'h0, 4'h0, 32'h0, 3'b000, 0, 0, acc);
      repeat (7) @(negedge clk);
      chk("timeout_cycle7", timeout, 0);
      @(negedge clk);
      chk("timeout_cycle8", timeout, 1);
      chk("arvalid_while_stuck", arvalid, 1);
      repeat (4) @(negedge clk);
      chk("timeout_sticky", timeout, 1);
      chk("arvalid_still_held", arvalid, 1);
      rst = 1;
      @(negedge clk);
      @(negedge clk);
      reset_checks("rst");
      rst = 0; ar_block = 0;
      @(negedge clk);
      issue(1, 0, 32'h10C, 32'h0BADF00D, 4'hF, 32'h0, 3'b000, 1, 1, acc);
      issue(0, 0, 32'h10C, 32'h0, 4'h0, 32'h0BADF00D, 3'b000, 1, 1, acc);
      drain();
      chk("timeout_after_reset", timeout, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no completion by cycle %0d, want finish", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/axil_req_master.md
Name: axil_req_master

Overview:
- Upstream master stage that converts a simple valid/ready request/response stream (CPU-native or switchboard-queue side) into AXI4-lite transactions.
- Drives the 32-bit AXI4-lite slave port of the simulation memory model with one outstanding transaction at a time.
- Returns read data or write completion on a response stream.
- Tracks AW/W handshakes independently, so it works with a slave that accepts address and data in any order or in any cycle.

Parameters:
- TIMEOUT, 0, cycles allowed in any bus-wait state before the sticky timeout flag is set; 0 disables the check
- CNT_W, 16, width of the timeout counter; TIMEOUT must be < 2**CNT_W

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid&ready
- req_write  in  1  1=write, 0=read
- req_insn  in  1  read is an instruction fetch
- req_addr  in  32  byte address
- req_wdata  in  32  write data
- req_wstrb  in  4  byte enables
- resp_valid  out  1  response present
- resp_ready  in  1  response consumed when valid&ready
- resp_write  out  1  response is a write completion
- resp_rdata  out  32  read data; 0 for writes
- mem_axi_awvalid/awready/awaddr[31:0]/awprot[2:0]  AXI4-lite AW, master side
- mem_axi_wvalid/wready/wdata[31:0]/wstrb[3:0]  AXI4-lite W
- mem_axi_bvalid/bready  AXI4-lite B
- mem_axi_arvalid/arready/araddr[31:0]/arprot[2:0]  AXI4-lite AR
- mem_axi_rvalid/rready/rdata[31:0]  AXI4-lite R
- timeout  out  1  sticky; set when TIMEOUT expires

Behaviour:
- Reset, synchronous: state=IDLE; all AXI valid/ready outputs 0; resp_valid=0; resp_write=0; resp_rdata=0; timeout=0; counter=0. Reset mid-transaction abandons it; the bench must also reset the slave.
- req_ready = (state==IDLE). Combinational from state only, never from req_valid.
- All AXI outputs and response outputs are registered.
- States:
  - IDLE, on req_valid&req_ready:
    - write: latch addr/wdata/wstrb; set awvalid=wvalid=1 next cycle; go WR.
    - read: latch addr; set arvalid=1 and arprot = req_insn ? 3'b100 : 3'b000; go RD_A.
  - WR: awvalid drops the cycle after awvalid&awready; wvalid drops the cycle after wvalid&wready; each is tracked independently. When both handshakes are done (same or different cycles), bready=1 and go WR_B. awprot=3'b000 always.
  - WR_B: on bvalid&bready: bready=0, resp_valid=1, resp_write=1, resp_rdata=0; go RESP.
  - RD_A: on arvalid&arready: arvalid=0, rready=1; go RD_R.
  - RD_R: on rvalid&rready: rready=0, capture rdata, resp_valid=1, resp_write=0; go RESP.
  - RESP: hold the response stable until resp_ready; then resp_valid=0 and go IDLE. A new request is accepted the following cycle; no same-cycle overlap.
- AXI rules:
  - A valid, once raised, is never lowered before its handshake.
  - Address, data, strb and prot stay stable while valid is high.
  - bready/rready are asserted only in WR_B/RD_R.
  - A bvalid or rvalid already high on entry to WR_B/RD_R completes in the first cycle of that state.
- Minimum latency: request accept -> resp_valid = 3 cycles for a zero-wait slave (issue, handshake, response/ready phase).
- Timeout:
  - Counter clears on entering any state and increments each cycle in WR, WR_B, RD_A, RD_R.
  - When TIMEOUT!=0 and counter==TIMEOUT-1, set timeout=1. It stays set until rst.
  - The transaction keeps waiting; the counter saturates and does not wrap.
- Addresses are passed through unmodified; no alignment check.

Decomposition:
- Shared package axil_pkg: state enum (IDLE, WR, WR_B, RD_A, RD_R, RESP), localparams PROT_DATA=3'b000 and PROT_INSN=3'b100, AXI-lite widths ADDR_W=32, DATA_W=32, STRB_W=4.
- No sub-module is required. The timeout counter may be split out as axil_timeout_ctr (count, clear, saturate, hit flag) for reuse by a future slave-side monitor.

Test Plan:
- Zero-wait slave, write addr 0x0000_0100 data 0xDEADBEEF strb 4'hF, then read 0x100 -> resp_write=1, then resp_rdata=0xDEADBEEF; each resp_valid exactly 3 cycles after req accept; arprot=000.
- Slave accepts W two cycles before AW (awready delayed 3, wready immediate), strb 4'b0011 data 0x1234_5678 over 0xFFFF_FFFF -> bready only after both handshakes; readback 0xFFFF5678.
- Instruction fetch req_insn=1 addr 0x0 -> arprot=3'b100 held stable through the handshake; arvalid never drops before arready.
- resp_ready held low 5 cycles with a second req_valid pending -> req_ready=0 throughout, resp outputs stable; second request accepted the cycle after the resp handshake.
- TIMEOUT=8, slave never asserts arready -> timeout=1 exactly 8 cycles after entering RD_A, arvalid stays 1; rst pulse -> all outputs 0, timeout=0, state IDLE.
- Randomised slave delays (xorshift-driven ready stalls, 1000 mixed transactions) -> scoreboard match and no AXI stability violations.
